ttt_game_ctrl: RTL and testbench
================================

# ttt_game_ctrl

Sequential game controller for the tic-tac-toe datapath. It accepts moves from one shared move port, alternates turns between player A and player B, and rejects illegal moves. It keeps the two 9-bit board registers and checks for a win or draw after every accepted move. It also enforces an optional per-turn timeout. Its `ain`/`bin` outputs drive the win-detection and display logic directly.

## Interface
- `TIMEOUT_CYCLES`, default 1000: cycles a player may wait before forfeiting; 0 disables the timeout.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `new_game` in 1: single-cycle pulse; clears the board and starts a game.
- `first_b` in 1: sampled with `new_game`; 1 means B moves first.
- `move_valid` in 1: a move is presented on `move_idx`.
- `move_idx` in 4: square index 0..8; bit i of `ain`/`bin` is square i.
- `move_ready` out 1: high in A_TURN and B_TURN only.
- `move_ack` out 1: one-cycle pulse, move accepted.
- `move_err` out 1: one-cycle pulse, move rejected.
- `ain` out 9: squares held by A.
- `bin` out 9: squares held by B.
- `turn_b` out 1: 1 when B is to move or was the last mover.
- `game_over` out 1: high in A_WIN, B_WIN and DRAW.
- `winner` out 2: 00 none, 01 A, 10 B, 11 draw.
- `win_line` out 8, one bit per line (several bits may be set):
  - bit0: row 8 7 6; bit1: row 5 4 3; bit2: row 2 1 0.
  - bit3: col 8 5 2; bit4: col 7 4 1; bit5: col 6 3 0.
  - bit6: diagonal 8 4 0; bit7: diagonal 2 4 6.
- `timeout_flag` out 1: game ended by forfeit.

## Operation
- States: IDLE, A_TURN, B_TURN, CHECK, A_WIN, B_WIN, DRAW.
- Reset (async, `rst_n`=0):
  - State goes to IDLE.
  - `ain`, `bin`, `win_line`, `winner` = 0.
  - `turn_b`, `move_ack`, `move_err`, `game_over`, `timeout_flag` = 0.
  - Timeout counter = 0.
- `new_game` is honoured in every state, including mid-game:
  - Clears `ain`/`bin`/`win_line`/`winner`/`timeout_flag`.
  - Next state is A_TURN, or B_TURN if `first_b`=1; `turn_b` = `first_b`.
  - `new_game` has priority over `move_valid` in the same cycle: the move is ignored, with no ack and no err.
- A move is legal only if all of the following hold:
  - The state is A_TURN or B_TURN.
  - `move_idx` ≤ 8.
  - Bit `move_idx` of (`ain`|`bin`) is 0.
- Legal move: set bit `move_idx` in the mover's board, pulse `move_ack`, go to CHECK.
- Illegal move while `move_ready`=1: pulse `move_err`; board, state and timeout counter are unchanged.
- `move_valid` while `move_ready`=0: ignored silently, no pulse.
- CHECK evaluates only the mover's board, as all eight lines OR-combined into `win_line`:
  - Any line bit set: go to A_WIN or B_WIN, `winner` set.
  - Otherwise, if (`ain`|`bin`) = 9'h1FF: go to DRAW, `winner`=11.
  - Otherwise go to the other player's turn and toggle `turn_b`.
- Timeout counter:
  - Cleared on entry to A_TURN/B_TURN and increments each cycle in those states.
  - If it reaches `TIMEOUT_CYCLES`-1 with no legal move that cycle, the waiting player forfeits: the opponent's WIN state, `timeout_flag`=1, `win_line`=0.
  - A legal move in the expiry cycle takes precedence over the forfeit.
- Terminal states hold all outputs until `new_game` or reset.

## Timing
- Accept edge E: `ain`/`bin` update at E. `move_ack` is high for exactly one cycle after E. The state is CHECK for one cycle after E, with `move_ready`=0.
- Result edge E+1: state goes to the next turn or a terminal state. `game_over`, `winner` and `win_line` become valid in the cycle after E+1. In a continuing game `move_ready` reasserts in that cycle.
- Minimum spacing between accepted moves: 2 cycles.
- Error path: `move_err` is high one cycle after the offending edge, and `move_ready` stays 1.
- Forfeit: a game with no moves ends `TIMEOUT_CYCLES` cycles after entering the turn state.
- Reset mid-operation takes effect immediately, with no pending ack/err.

## Test plan
- A diagonal win:
  - Stimulus: `new_game` with `first_b`=0, then moves A4, B0, A2, B1, A6.
  - Required: five acks; `ain`=9'h054, `bin`=9'h003; `winner`=01, `win_line`=8'h80, `game_over`=1.
- Illegal moves:
  - Stimulus: A plays idx 4, then B plays idx 4, then B plays idx 9.
  - Required: `move_err` pulses twice, `bin` stays 0, state stays B_TURN.
- Draw:
  - Stimulus: alternating sequence A0, B1, A2, B4, A3, B5, A7, B6, A8.
  - Required: `ain`=9'h18D, `bin`=9'h072, `winner`=11, `win_line`=0.
- Double line:
  - Stimulus: a final A move on idx 8 that completes both row 8 7 6 and col 8 5 2.
  - Required: `win_line`=8'h09.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=8, `new_game`, no moves.
  - Required: 8 cycles later `winner`=10, `timeout_flag`=1.
  - Variant: a legal move in cycle 7 of the turn is acked and there is no forfeit.
- Restart and reset priority:
  - Stimulus: `new_game` together with `move_valid` mid-game; separately, `rst_n` low during CHECK.
  - Required: boards are cleared with no ack. After reset all outputs are 0 and the state is IDLE, so `move_ready`=0.

Source files
------------

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe game controller: turn sequencing, move legality,
// win/draw detection and per-turn forfeit timeout.
module ttt_game_ctrl #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_new_game,
   input  logic       i_first_b,
   input  logic       i_move_valid,
   input  logic [3:0] i_move_idx,
   output logic       o_move_ready,
   output logic       o_move_ack,
   output logic       o_move_err,
   output logic [8:0] o_ain,
   output logic [8:0] o_bin,
   output logic       o_turn_b,
   output logic       o_game_over,
   output logic [1:0] o_winner,
   output logic [7:0] o_win_line,
   output logic       o_timeout_flag
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_A_TURN, S_B_TURN, S_CHECK, S_A_WIN, S_B_WIN, S_DRAW
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [8:0]      r_ain, r_bin, w_ain_nxt, w_bin_nxt;
   logic            r_turn_b, w_turn_b_nxt;
   logic            r_ack, r_err, w_ack_nxt, w_err_nxt;
   logic [1:0]      r_winner, w_winner_nxt;
   logic [7:0]      r_win_line, w_win_line_nxt;
   logic            r_tflag, w_tflag_nxt;
   logic [TW-1:0]   r_tcnt, w_tcnt_nxt;

   logic            w_in_turn, w_legal, w_expire;
   logic [8:0]      w_occ, w_sel;
   logic [7:0]      w_lines;

   // Bit order matches the win_line encoding: bit0 row 876 ... bit7 diagonal 246.
   function automatic logic [7:0] f_lines(input logic [8:0] b);
      f_lines = {b[2] & b[4] & b[6], b[8] & b[4] & b[0], b[6] & b[3] & b[0],
                 b[7] & b[4] & b[1], b[8] & b[5] & b[2], b[2] & b[1] & b[0],
                 b[5] & b[4] & b[3], b[8] & b[7] & b[6]};
   endfunction

   assign w_in_turn = (r_state == S_A_TURN) || (r_state == S_B_TURN);
   assign w_occ     = r_ain | r_bin;
   assign w_sel     = 9'(1) << i_move_idx;
   assign w_legal   = w_in_turn && i_move_valid && (i_move_idx <= 4'd8) && ((w_occ & w_sel) == 9'd0);
   assign w_expire  = (TIMEOUT_CYCLES != 0) && (r_tcnt == T_LIM);
   assign w_lines   = f_lines(r_turn_b ? r_bin : r_ain);

   always_comb begin
      w_state_nxt    = r_state;
      w_ain_nxt      = r_ain;
      w_bin_nxt      = r_bin;
      w_turn_b_nxt   = r_turn_b;
      w_ack_nxt      = 1'b0;
      w_err_nxt      = 1'b0;
      w_winner_nxt   = r_winner;
      w_win_line_nxt = r_win_line;
      w_tflag_nxt    = r_tflag;
      w_tcnt_nxt     = r_tcnt;

      case (r_state)
         S_A_TURN, S_B_TURN: begin
            if (w_legal) begin
               if (r_state == S_B_TURN) w_bin_nxt = r_bin | w_sel;
               else                     w_ain_nxt = r_ain | w_sel;
               w_ack_nxt   = 1'b1;
               w_state_nxt = S_CHECK;
            end else begin
               w_err_nxt = i_move_valid;
               if (w_expire) begin
                  // The waiting player forfeits to the opponent.
                  w_state_nxt    = (r_state == S_A_TURN) ? S_B_WIN : S_A_WIN;
                  w_winner_nxt   = (r_state == S_A_TURN) ? 2'b10 : 2'b01;
                  w_win_line_nxt = 8'd0;
                  w_tflag_nxt    = 1'b1;
               end else if (TIMEOUT_CYCLES != 0) begin
                  w_tcnt_nxt = r_tcnt + TW'(1);
               end
            end
         end
         S_CHECK: begin
            w_win_line_nxt = w_lines;
            w_tcnt_nxt     = '0;
            if (w_lines != 8'd0) begin
               w_state_nxt  = r_turn_b ? S_B_WIN : S_A_WIN;
               w_winner_nxt = r_turn_b ? 2'b10 : 2'b01;
            end else if (w_occ == 9'h1FF) begin
               w_state_nxt  = S_DRAW;
               w_winner_nxt = 2'b11;
            end else begin
               w_state_nxt  = r_turn_b ? S_A_TURN : S_B_TURN;
               w_turn_b_nxt = ~r_turn_b;
            end
         end
         default: ;
      endcase

      if (i_new_game) begin
         w_state_nxt    = i_first_b ? S_B_TURN : S_A_TURN;
         w_ain_nxt      = 9'd0;
         w_bin_nxt      = 9'd0;
         w_turn_b_nxt   = i_first_b;
         w_ack_nxt      = 1'b0;
         w_err_nxt      = 1'b0;
         w_winner_nxt   = 2'b00;
         w_win_line_nxt = 8'd0;
         w_tflag_nxt    = 1'b0;
         w_tcnt_nxt     = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_ain      <= 9'd0;
         r_bin      <= 9'd0;
         r_turn_b   <= 1'b0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_winner   <= 2'b00;
         r_win_line <= 8'd0;
         r_tflag    <= 1'b0;
         r_tcnt     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ain      <= w_ain_nxt;
         r_bin      <= w_bin_nxt;
         r_turn_b   <= w_turn_b_nxt;
         r_ack      <= w_ack_nxt;
         r_err      <= w_err_nxt;
         r_winner   <= w_winner_nxt;
         r_win_line <= w_win_line_nxt;
         r_tflag    <= w_tflag_nxt;
         r_tcnt     <= w_tcnt_nxt;
      end
   end

   assign o_move_ready   = w_in_turn;
   assign o_move_ack     = r_ack;
   assign o_move_err     = r_err;
   assign o_ain          = r_ain;
   assign o_bin          = r_bin;
   assign o_turn_b       = r_turn_b;
   assign o_game_over    = (r_state == S_A_WIN) || (r_state == S_B_WIN) || (r_state == S_DRAW);
   assign o_winner       = r_winner;
   assign o_win_line     = r_win_line;
   assign o_timeout_flag = r_tflag;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - scoreboard bench for ttt_game_ctrl with an 8-cycle turn timeout.
module tb_ttt_game_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_new_game = 1'b0;
   logic       i_first_b = 1'b0;
   logic       i_move_valid = 1'b0;
   logic [3:0] i_move_idx = 4'd0;
   logic       o_move_ready, o_move_ack, o_move_err, o_turn_b, o_game_over, o_timeout_flag;
   logic [8:0] o_ain, o_bin;
   logic [1:0] o_winner;
   logic [7:0] o_win_line;

   always #5 clk = ~clk;

   ttt_game_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .i_new_game(i_new_game), .i_first_b(i_first_b),
      .i_move_valid(i_move_valid), .i_move_idx(i_move_idx),
      .o_move_ready(o_move_ready), .o_move_ack(o_move_ack), .o_move_err(o_move_err),
      .o_ain(o_ain), .o_bin(o_bin), .o_turn_b(o_turn_b), .o_game_over(o_game_over),
      .o_winner(o_winner), .o_win_line(o_win_line), .o_timeout_flag(o_timeout_flag)
   );

   typedef struct {
      logic       ack;
      logic [8:0] ain;
      logic [8:0] bin;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         n_tot = 0;
   int         n_bad = 0;
   logic [8:0] m_ain = 9'd0;
   logic [8:0] m_bin = 9'd0;
   logic       m_turn_b = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Every ack/err pulse must match the oldest expectation in the scoreboard.
   always @(negedge clk) begin
      if (rst_n && (o_move_ack || o_move_err)) begin
         if (sb.size() == 0) begin
            chk("unexp_pulse", 32'({o_move_ack, o_move_err}), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("pulse", 32'({o_move_ack, o_move_err}), mon_e.ack ? 32'd2 : 32'd1);
            chk("pulse_ain", 32'(o_ain), 32'(mon_e.ain));
            chk("pulse_bin", 32'(o_bin), 32'(mon_e.bin));
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!o_move_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!o_move_ready) chk("ready_wait", 32'(o_move_ready), 32'd1);
   endtask

   task automatic drive_move(input logic [3:0] idx);
      logic       legal;
      logic [8:0] occ;
      exp_t       e;
      occ   = m_ain | m_bin;
      legal = (idx <= 4'd8) ? !occ[idx] : 1'b0;
      if (legal) begin
         if (m_turn_b) m_bin[idx] = 1'b1;
         else          m_ain[idx] = 1'b1;
      end
      e.ack = legal;
      e.ain = m_ain;
      e.bin = m_bin;
      sb.push_back(e);
      i_move_valid = 1'b1;
      i_move_idx   = idx;
      @(posedge clk); #1;
      i_move_valid = 1'b0;
      if (legal) begin
         chk("check_rdy", 32'(o_move_ready), 32'd0);
         m_turn_b = ~m_turn_b;
      end else begin
         chk("err_rdy", 32'(o_move_ready), 32'd1);
      end
   endtask

   task automatic mv(input logic [3:0] idx);
      wait_ready();
      drive_move(idx);
   endtask

   task automatic ng(input logic fb, input logic with_mv);
      i_new_game   = 1'b1;
      i_first_b    = fb;
      i_move_valid = with_mv;
      i_move_idx   = 4'd3;
      @(posedge clk); #1;
      i_new_game   = 1'b0;
      i_move_valid = 1'b0;
      m_ain = 9'd0; m_bin = 9'd0; m_turn_b = fb;
      chk("ng_ain", 32'(o_ain), 32'd0);
      chk("ng_bin", 32'(o_bin), 32'd0);
      chk("ng_turn", 32'(o_turn_b), 32'(fb));
      chk("ng_rdy", 32'(o_move_ready), 32'd1);
      chk("ng_over", 32'(o_game_over), 32'd0);
      chk("ng_winner", 32'(o_winner), 32'd0);
      chk("ng_tflag", 32'(o_timeout_flag), 32'd0);
   endtask

   task automatic result(input logic [1:0] w, input logic [7:0] wl, input logic tf);
      @(posedge clk); #1;
      chk("res_winner", 32'(o_winner), 32'(w));
      chk("res_line", 32'(o_win_line), 32'(wl));
      chk("res_over", 32'(o_game_over), 32'd1);
      chk("res_tflag", 32'(o_timeout_flag), 32'(tf));
      chk("res_rdy", 32'(o_move_ready), 32'd0);
      chk("res_ain", 32'(o_ain), 32'(m_ain));
      chk("res_bin", 32'(o_bin), 32'(m_bin));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ain", 32'(o_ain), 32'd0);
      chk("rst_bin", 32'(o_bin), 32'd0);
      chk("rst_misc", 32'({o_turn_b, o_move_ack, o_move_err, o_game_over, o_timeout_flag, o_move_ready}), 32'd0);
      chk("rst_winner", 32'({o_winner, o_win_line}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Move presented in IDLE is ignored silently.
      i_move_valid = 1'b1; i_move_idx = 4'd0;
      @(posedge clk); #1;
      i_move_valid = 1'b0;
      chk("idle_ain", 32'(o_ain), 32'd0);
      chk("idle_rdy", 32'(o_move_ready), 32'd0);

      // Diagonal 2-4-6 win for A.
      ng(1'b0, 1'b0);
      mv(4); mv(0); mv(2); mv(1); mv(6);
      result(2'b01, 8'h80, 1'b0);
      chk("diag_ain", 32'(o_ain), 32'h054);
      chk("diag_bin", 32'(o_bin), 32'h003);
      i_move_valid = 1'b1; i_move_idx = 4'd8;
      @(posedge clk); #1;
      i_move_valid = 1'b0;
      @(posedge clk); #1;
      chk("term_ain", 32'(o_ain), 32'h054);
      chk("term_winner", 32'(o_winner), 32'd1);

      // Illegal moves: occupied square, then out-of-range index.
      ng(1'b0, 1'b0);
      mv(4); mv(4); mv(9);
      @(posedge clk); #1;
      chk("ill_bin", 32'(o_bin), 32'd0);
      chk("ill_turn", 32'(o_turn_b), 32'd1);
      chk("ill_rdy", 32'(o_move_ready), 32'd1);
      chk("ill_over", 32'(o_game_over), 32'd0);

      // Restart mid-game with a move in the same cycle, then a full-board draw.
      ng(1'b0, 1'b1);
      mv(0); mv(1); mv(2); mv(4); mv(3); mv(5); mv(7); mv(6); mv(8);
      result(2'b11, 8'h00, 1'b0);
      chk("draw_ain", 32'(o_ain), 32'h18D);
      chk("draw_bin", 32'(o_bin), 32'h072);

      // Final A move on 8 completes row 8-7-6 and column 8-5-2 together.
      ng(1'b0, 1'b0);
      mv(6); mv(0); mv(7); mv(1); mv(2); mv(3); mv(5); mv(4); mv(8);
      result(2'b01, 8'h09, 1'b0);
      chk("dbl_ain", 32'(o_ain), 32'h1E4);

      // B moves first.
      ng(1'b1, 1'b0);
      mv(4);
      @(posedge clk); #1;
      chk("bfirst_bin", 32'(o_bin), 32'h010);
      chk("bfirst_turn", 32'(o_turn_b), 32'd0);

      // Forfeit after 8 idle cycles in A_TURN.
      ng(1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      chk("to_pre_over", 32'(o_game_over), 32'd0);
      result(2'b10, 8'h00, 1'b1);

      // Legal move in the expiry cycle wins over the forfeit.
      ng(1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      drive_move(4);
      @(posedge clk); #1;
      chk("tov_over", 32'(o_game_over), 32'd0);
      chk("tov_tflag", 32'(o_timeout_flag), 32'd0);
      chk("tov_turn", 32'(o_turn_b), 32'd1);
      chk("tov_ain", 32'(o_ain), 32'h010);

      // Reset while in CHECK drops the pending ack.
      ng(1'b0, 1'b0);
      wait_ready();
      i_move_valid = 1'b1; i_move_idx = 4'd0;
      @(posedge clk); #1;
      i_move_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rc_ain", 32'(o_ain), 32'd0);
      chk("rc_ack", 32'({o_move_ack, o_move_err}), 32'd0);
      chk("rc_misc", 32'({o_turn_b, o_game_over, o_timeout_flag, o_move_ready, o_winner, o_win_line}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rc_rdy", 32'(o_move_ready), 32'd0);
      m_ain = 9'd0; m_bin = 9'd0; m_turn_b = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad + 1);
      $fatal(1);
   end

endmodule
